// File: rtl/piso_reg_frame.sv
// Parametrised 165-style parallel-in/serial-out register with frame counter
// and busy/done/overrun status.
module piso_reg_frame #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1,
    localparam int CNT_W    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clk_inh,
    input  logic             LOAD,
    input  logic             SER,
    input  logic [WIDTH-1:0] D_in,
    output logic             Q,
    output logic             QNEG,
    output logic             busy,
    output logic             done,
    output logic             ovr,
    output logic [CNT_W-1:0] bit_cnt
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] shreg, shift_nxt;

    generate
        if (MSB_FIRST) begin : g_msb
            assign shift_nxt = {shreg[WIDTH-2:0], SER};
            assign Q         = shreg[WIDTH-1];
        end else begin : g_lsb
            assign shift_nxt = {SER, shreg[WIDTH-1:1]};
            assign Q         = shreg[0];
        end
    endgenerate

    assign QNEG = ~Q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // LOAD wins over inhibit; inhibit freezes SHIFT but never stretches DONE.
    always_comb begin
        state_nxt = state;
        if (!LOAD) begin
            state_nxt = SHIFT;
        end else begin
            case (state)
                SHIFT:   if (!clk_inh && bit_cnt == CNT_W'(1)) state_nxt = DONE;
                DONE:    state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state)
            SHIFT:   busy = 1'b1;
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    // Shifting runs in every state so cascaded/free-running use still works.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg   <= '0;
            bit_cnt <= '0;
            ovr     <= 1'b0;
        end else begin
            ovr <= !LOAD && (state == SHIFT);
            if (!LOAD) begin
                shreg   <= D_in;
                bit_cnt <= CNT_W'(WIDTH);
            end else if (!clk_inh) begin
                shreg <= shift_nxt;
                if (state == SHIFT) bit_cnt <= bit_cnt - CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_piso_reg_frame.sv
// Scoreboard bench: an MSB-first and an LSB-first instance share stimulus;
// expected serial bits are queued at load and popped on every shift edge.
module tb_piso_reg_frame;

    logic       clk_tb = 1'b0;
    logic       rst, clk_inh, LOAD, SER;
    logic [7:0] D_in;
    logic       q_m, qn_m, busy_m, done_m, ovr_m;
    logic       q_l, qn_l, busy_l, done_l, ovr_l;
    logic [3:0] cnt_m, cnt_l;

    int n_chk = 0;
    int n_err = 0;
    logic q_msb[$];
    logic q_lsb[$];

    always #5 clk_tb = ~clk_tb;

    piso_reg_frame #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk_tb), .rst(rst), .clk_inh(clk_inh), .LOAD(LOAD), .SER(SER),
        .D_in(D_in), .Q(q_m), .QNEG(qn_m), .busy(busy_m), .done(done_m),
        .ovr(ovr_m), .bit_cnt(cnt_m)
    );

    piso_reg_frame #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk_tb), .rst(rst), .clk_inh(clk_inh), .LOAD(LOAD), .SER(SER),
        .D_in(D_in), .Q(q_l), .QNEG(qn_l), .busy(busy_l), .done(done_l),
        .ovr(ovr_l), .bit_cnt(cnt_l)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic step;
        @(posedge clk_tb);
        #1;
    endtask

    task automatic do_load(input logic [7:0] d);
        D_in = d;
        LOAD = 1'b0;
        step();
        LOAD = 1'b1;
    endtask

    // Load d, shift it out with SER=ser, inserting inh_len inhibit cycles
    // once inh_at bits have gone. Returns sampled in the DONE cycle.
    task automatic run_frame(input logic [7:0] d, input logic ser,
                             input int inh_at, input int inh_len);
        int shifts = 0;
        int edges  = 0;
        int inh_left = inh_len;
        SER = ser;
        do_load(d);
        q_msb.delete();
        q_lsb.delete();
        for (int i = 7; i >= 0; i--) q_msb.push_back(d[i]);
        for (int i = 0; i < 8; i++)  q_lsb.push_back(d[i]);
        chk("ovr_on_clean_load", 32'(ovr_m), 32'd0);
        while (shifts < 8 && edges < 40) begin
            chk("msb_q", 32'(q_m), 32'(q_msb[0]));
            chk("msb_qneg", 32'(qn_m), 32'(!q_msb[0]));
            chk("lsb_q", 32'(q_l), 32'(q_lsb[0]));
            chk("msb_cnt", 32'(cnt_m), 32'(8 - shifts));
            chk("lsb_cnt", 32'(cnt_l), 32'(8 - shifts));
            chk("busy", 32'({busy_m, busy_l}), 32'd3);
            chk("done_early", 32'({done_m, done_l}), 32'd0);
            clk_inh = (shifts == inh_at) && (inh_left > 0);
            if (clk_inh) inh_left--;
            step();
            edges++;
            if (!clk_inh) begin
                void'(q_msb.pop_front());
                void'(q_lsb.pop_front());
                shifts++;
            end
        end
        clk_inh = 1'b0;
        chk("latency", 32'(edges), 32'(8 + inh_len));
        chk("done", 32'({done_m, done_l}), 32'd3);
        chk("busy_in_done", 32'({busy_m, busy_l}), 32'd0);
        chk("cnt_in_done", 32'(cnt_m), 32'd0);
        chk("q_after_frame", 32'({q_m, q_l}), 32'({ser, ser}));
        chk("qneg_after_frame", 32'(qn_l), 32'(!ser));
    endtask

    initial begin
        rst = 1'b1; clk_inh = 1'b0; LOAD = 1'b1; SER = 1'b0; D_in = 8'h00;
        step(); step();
        chk("rst_q_qneg", 32'({q_m, qn_m, q_l, qn_l}), 32'b0101);
        chk("rst_status", 32'({busy_m, done_m, ovr_m}), 32'd0);
        chk("rst_cnt", 32'(cnt_m), 32'd0);
        rst = 1'b0;
        step();

        // Plain MSB/LSB frame, SER=0; done must be a single-cycle pulse.
        run_frame(8'hAB, 1'b0, -1, 0);
        step();
        chk("done_width", 32'({done_m, done_l}), 32'd0);
        chk("idle_busy", 32'(busy_m), 32'd0);

        // LSB-first pattern with SER=1 so Q ends high.
        run_frame(8'h97, 1'b1, -1, 0);
        step();
        chk("done_width2", 32'(done_l), 32'd0);
        chk("idle_cnt", 32'(cnt_l), 32'd0);

        // Inhibit 4 cycles after 2 shifts: Q frozen on bit5, cnt 6.
        run_frame(8'h66, 1'b0, 2, 4);
        step();

        // Async reset mid-frame, asserted between edges.
        SER = 1'b0;
        do_load(8'hAB);
        step(); step(); step();
        #2 rst = 1'b1;
        #1;
        chk("arst_q_qneg", 32'({q_m, qn_m}), 32'b01);
        chk("arst_busy", 32'(busy_m), 32'd0);
        chk("arst_cnt", 32'(cnt_m), 32'd0);
        #1 rst = 1'b0;
        step();
        chk("post_rst_idle", 32'({busy_m, done_m, q_m}), 32'd0);

        // Overrun: reload mid-frame; first frame never reports done.
        do_load(8'hAB);
        step(); step(); step();
        chk("pre_ovr", 32'(ovr_m), 32'd0);
        do_load(8'h97);
        chk("ovr_pulse", 32'({ovr_m, ovr_l}), 32'd3);
        chk("ovr_cnt", 32'(cnt_m), 32'd8);
        chk("ovr_q", 32'({q_m, q_l}), 32'd3);
        for (int k = 1; k < 8; k++) begin
            step();
            chk("ovr_width", 32'(ovr_m), 32'd0);
            chk("no_done_aborted", 32'(done_m), 32'd0);
        end
        step();
        chk("done_after_reload", 32'(done_m), 32'd1);
        step();

        // Back-to-back: second load lands on the DONE cycle.
        run_frame(8'hAB, 1'b0, -1, 0);
        run_frame(8'h97, 1'b1, -1, 0);
        step();
        chk("b2b_done_width", 32'(done_m), 32'd0);
        chk("b2b_idle", 32'(busy_m), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
